mc_main_control: RTL

Multi-cycle main control unit for the MIPS core. It is a registered Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, including the 2-bit `ALUOp` consumed by the ALU control decoder. It also keeps cycle and retired-instruction counters for the bench and for performance readout.

---
 rtl/mc_ctrl_if.sv | 39 +++
 rtl/mc_main_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the MIPS datapath.
// The controller (master) reads the opcode and the ALU zero flag and drives every
// datapath enable, mux select, the debug state code and the performance counters.
// There is no handshake: every output is a level that is valid for the whole cycle
// and changes only after a rising clock edge (or when reset is raised or dropped).
interface mc_ctrl_if;
  logic [5:0]  opcode;
  logic        Zero;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic [1:0]  ALUOp;
  logic [3:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  modport master (
    input  opcode, Zero,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           state, cycle_cnt, inst_cnt
  );

  modport slave (
    output opcode, Zero,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
           state, cycle_cnt, inst_cnt
  );
endinterface

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control: registered Moore FSM stepping each instruction
// through fetch, decode, execute, memory and writeback, plus cycle and
// retired-instruction counters. Outputs depend on the state register only,
// except that reset parks them at the fetch values with all writes disabled.
module mc_main_control (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_if.master     bus
);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_LWWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  // The register is a plain 4-bit vector so codes 12..15 are representable
  // and recover to fetch.
  logic [3:0]  state_q;
  logic [3:0]  state_d;
  logic        retire;
  logic [31:0] cycle_cnt_q;
  logic [31:0] inst_cnt_q;

  // The zero flag is consumed by the datapath together with PCWriteCond.
  logic unused_zero;
  assign unused_zero = bus.Zero;

  // State register and wrapping counters; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IF;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire) inst_cnt_q <= inst_cnt_q + 32'd1;
    end
  end

  // Next-state selection; retire marks the last cycle of an instruction.
  always_comb begin
    state_d = S_IF;
    retire  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (bus.opcode)
          OPC_LW, OPC_SW: state_d = S_MEMADR;
          OPC_RTYPE:      state_d = S_REX;
          OPC_BNE:        state_d = S_BR;
          OPC_J:          state_d = S_JMP;
          OPC_ADDIU:      state_d = S_IEX;
          default: begin
            // Unknown opcode behaves as a NOP and still retires.
            state_d = S_IF;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_LWWB;
      S_REX:    state_d = S_RWB;
      S_IEX:    state_d = S_IWB;
      S_LWWB, S_MEMWR, S_RWB, S_BR, S_JMP, S_IWB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      default: state_d = S_IF;
    endcase
  end

  // Moore output decode; reset forces fetch selects with every write disabled.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.ALUOp       = 2'b00;
    if (rst) begin
      bus.ALUSrcB = 2'b01;
    end else begin
      case (state_q)
        S_IF: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.PCWrite = 1'b1;
        end
        S_ID: bus.ALUSrcB = 2'b11;
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        S_LWWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
        end
        S_REX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        S_RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BR: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
        end
        S_JMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
        S_IEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = 2'b11;
        end
        S_IWB: bus.RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.inst_cnt  = inst_cnt_q;

endmodule
